// File: rtl/apb_tx_pkg.sv
// Shared constants for the multi-channel APB TX register bank: register
// offsets, STATUS/INTFLAG bit positions and the per-channel register set.
package apb_tx_pkg;

    localparam logic [4:0] OFS_PRESCALE  = 5'h00;
    localparam logic [4:0] OFS_COMMAND   = 5'h04;
    localparam logic [4:0] OFS_TXDATA    = 5'h08;
    localparam logic [4:0] OFS_ID        = 5'h0C;
    localparam logic [4:0] OFS_DATAFIELD = 5'h10;
    localparam logic [4:0] OFS_STATUS    = 5'h14;
    localparam logic [4:0] OFS_INTFLAG   = 5'h18;
    localparam logic [4:0] OFS_INTEN     = 5'h1C;

    localparam int ST_BUSY  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_FULL  = 2;
    localparam int ST_LEVEL = 6;

    localparam int IF_OVF   = 0;
    localparam int IF_DRAIN = 1;
    localparam int IF_DONE  = 2;

    localparam int CMD_START = 3;

    typedef struct packed {
        logic [15:0] prescale;
        logic [7:0]  command;
        logic [7:0]  id;
        logic [15:0] datafield;
        logic [2:0]  intflag;
        logic [2:0]  inten;
    } ch_regs_t;

endpackage

// File: rtl/apb_tx_fifo.sv
// Single-clock TX data FIFO with level output; full/empty come from the
// registered level, so a push while full is dropped even if a pop coincides.
module apb_tx_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 8,
    localparam int PW = $clog2(DEPTH),
    localparam int LW = PW + 1
) (
    input  logic             PCLK_tx,
    input  logic             PRESETn_tx,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [LW-1:0]    level,
    output logic             empty,
    output logic             full
);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [PW-1:0]               wr_ptr;
    logic [PW-1:0]               rd_ptr;
    logic                        do_push;
    logic                        do_pop;

    assign empty   = (level == '0);
    assign full    = (level == LW'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge PCLK_tx or negedge PRESETn_tx) begin
        if (!PRESETn_tx) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            level <= level + LW'(do_push) - LW'(do_pop);
        end
    end

    // Storage needs no reset: the head word is don't-care while empty.
    always_ff @(posedge PCLK_tx) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/apb_tx_regbank.sv
// APB slave register bank serving NUM_CH TX channels, each with its own
// control registers, TX data FIFO and W1C interrupt flags.
module apb_tx_regbank
    import apb_tx_pkg::*;
#(
    parameter int ADDRESSWIDTH = 8,
    parameter int DATAWIDTH    = 16,
    parameter int NUM_CH       = 2,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                    PCLK_tx,
    input  logic                    PRESETn_tx,
    input  logic [ADDRESSWIDTH-1:0] PADDR_tx_i,
    input  logic [DATAWIDTH-1:0]    PWDATA_tx_i,
    input  logic                    PWRITE_tx_i,
    input  logic                    PSELx_tx_i,
    input  logic                    PENABLE_tx_i,
    output logic [DATAWIDTH-1:0]    PRDATA_tx_o,
    output logic                    PREADY_tx_o,
    output logic                    PSLVERR_tx_o,
    output logic [NUM_CH*16-1:0]    prescale_o,
    output logic [NUM_CH*8-1:0]     command_o,
    output logic [NUM_CH*8-1:0]     id_o,
    output logic [NUM_CH*16-1:0]    datafield_o,
    output logic [NUM_CH*12-1:0]    tx_data_o,
    output logic [NUM_CH-1:0]       tx_valid_o,
    input  logic [NUM_CH-1:0]       tx_ready_i,
    input  logic [NUM_CH-1:0]       busy_i,
    output logic                    irq_o
);

    localparam int CHW = ADDRESSWIDTH - 5;
    localparam int LW  = $clog2(FIFO_DEPTH) + 1;

    logic [CHW-1:0]            chan;
    logic [4:0]                ofs;
    logic                      setup;
    logic                      access;
    logic                      misal;
    logic                      err;
    logic                      wr_en;
    logic [NUM_CH-1:0]         ch_sel;
    logic [NUM_CH-1:0]         fifo_full;
    logic [NUM_CH-1:0]         fifo_empty;
    logic [NUM_CH-1:0]         irq_ch;
    logic [NUM_CH-1:0][LW-1:0] fifo_level;
    logic [NUM_CH-1:0][15:0]   rd_ch;
    logic [15:0]               rd16;
    logic [DATAWIDTH-1:0]      rd_mux;

    assign chan   = PADDR_tx_i[ADDRESSWIDTH-1:5];
    assign ofs    = PADDR_tx_i[4:0];
    assign setup  = PSELx_tx_i & ~PENABLE_tx_i;
    assign access = PSELx_tx_i & PENABLE_tx_i;
    assign misal  = |ofs[1:0];

    // ch_sel is all-zero for an out-of-range channel, which doubles as the range check.
    assign err = ~(|ch_sel) | misal
               | (PWRITE_tx_i & (ofs == OFS_STATUS))
               | (PWRITE_tx_i & (ofs == OFS_TXDATA) & (|(ch_sel & fifo_full)));

    assign PSLVERR_tx_o = access & err;
    assign PREADY_tx_o  = 1'b1;
    assign wr_en        = access & PWRITE_tx_i & ~err;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        ch_regs_t    r;
        logic        busy_q;
        logic        wr_c;
        logic        push;
        logic        pop;
        logic [2:0]  set;
        logic [2:0]  clr;
        logic [15:0] rd;

        assign ch_sel[c] = (chan == CHW'(c));
        assign wr_c      = wr_en & ch_sel[c];
        assign push      = wr_c & (ofs == OFS_TXDATA);
        assign pop       = ~fifo_empty[c] & tx_ready_i[c];

        always_comb begin
            set           = '0;
            set[IF_OVF]   = access & PWRITE_tx_i & ch_sel[c] & (ofs == OFS_TXDATA) & fifo_full[c];
            set[IF_DRAIN] = pop & ~push & (fifo_level[c] == LW'(1));
            set[IF_DONE]  = busy_q & ~busy_i[c];
            clr           = (wr_c && ofs == OFS_INTFLAG) ? PWDATA_tx_i[2:0] : 3'b000;
        end

        always_ff @(posedge PCLK_tx or negedge PRESETn_tx) begin
            if (!PRESETn_tx) begin
                r      <= '0;
                busy_q <= 1'b0;
            end else begin
                busy_q    <= busy_i[c];
                r.intflag <= (r.intflag & ~clr) | set;
                if (wr_c) begin
                    case (ofs)
                        OFS_PRESCALE:  r.prescale  <= PWDATA_tx_i[15:0];
                        OFS_ID:        r.id        <= PWDATA_tx_i[7:0];
                        OFS_DATAFIELD: r.datafield <= PWDATA_tx_i[15:0];
                        OFS_INTEN:     r.inten     <= PWDATA_tx_i[2:0];
                        default:       ;
                    endcase
                end
                // Software write wins over the hardware start-bit clear.
                if (wr_c && ofs == OFS_COMMAND)
                    r.command <= PWDATA_tx_i[7:0];
                else if (busy_i[c] && r.command[CMD_START])
                    r.command[CMD_START] <= 1'b0;
            end
        end

        always_comb begin
            rd = '0;
            case (ofs)
                OFS_PRESCALE:  rd = r.prescale;
                OFS_COMMAND:   rd[7:0] = r.command;
                OFS_ID:        rd[7:0] = r.id;
                OFS_DATAFIELD: rd = r.datafield;
                OFS_STATUS: begin
                    rd[ST_BUSY]       = busy_i[c];
                    rd[ST_EMPTY]      = fifo_empty[c];
                    rd[ST_FULL]       = fifo_full[c];
                    rd[ST_LEVEL +: LW] = fifo_level[c];
                end
                OFS_INTFLAG:   rd[2:0] = r.intflag;
                OFS_INTEN:     rd[2:0] = r.inten;
                default:       rd = '0;
            endcase
        end

        assign rd_ch[c] = rd;

        apb_tx_fifo #(.WIDTH(12), .DEPTH(FIFO_DEPTH)) u_fifo (
            .PCLK_tx    (PCLK_tx),
            .PRESETn_tx (PRESETn_tx),
            .push       (push),
            .pop        (pop),
            .wdata      (PWDATA_tx_i[11:0]),
            .rdata      (tx_data_o[c*12 +: 12]),
            .level      (fifo_level[c]),
            .empty      (fifo_empty[c]),
            .full       (fifo_full[c])
        );

        assign tx_valid_o[c]          = ~fifo_empty[c];
        assign prescale_o[c*16 +: 16] = r.prescale;
        assign command_o[c*8 +: 8]    = r.command;
        assign id_o[c*8 +: 8]         = r.id;
        assign datafield_o[c*16 +: 16] = r.datafield;
        assign irq_ch[c]              = |(r.intflag & r.inten);
    end

    always_comb begin
        rd16 = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_sel[c]) rd16 = rd16 | rd_ch[c];
        end
        if (misal) rd16 = '0;
        rd_mux = '0;
        rd_mux[15:0] = rd16;
    end

    always_ff @(posedge PCLK_tx or negedge PRESETn_tx) begin
        if (!PRESETn_tx) begin
            PRDATA_tx_o <= '0;
            irq_o       <= 1'b0;
        end else begin
            if (setup) PRDATA_tx_o <= rd_mux;
            irq_o <= |irq_ch;
        end
    end

endmodule

// File: tb/tb_apb_tx_regbank.sv
// Directed plus randomized bench for apb_tx_regbank against a queue-based
// behavioural model of the register map, FIFOs and interrupt flags.
module tb_apb_tx_regbank;

    localparam int AW  = 8;
    localparam int DW  = 16;
    localparam int NCH = 2;
    localparam int DEP = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [AW-1:0]     paddr = '0;
    logic [DW-1:0]     pwdata = '0;
    logic              pwrite = 1'b0;
    logic              psel = 1'b0;
    logic              penable = 1'b0;
    logic [DW-1:0]     prdata;
    logic              pready;
    logic              pslverr;
    logic [NCH*16-1:0] prescale_o;
    logic [NCH*8-1:0]  command_o;
    logic [NCH*8-1:0]  id_o;
    logic [NCH*16-1:0] datafield_o;
    logic [NCH*12-1:0] tx_data_o;
    logic [NCH-1:0]    tx_valid_o;
    logic [NCH-1:0]    tx_ready = '0;
    logic [NCH-1:0]    busy = '0;
    logic              irq;

    always #5 clk = ~clk;

    apb_tx_regbank #(.ADDRESSWIDTH(AW), .DATAWIDTH(DW), .NUM_CH(NCH), .FIFO_DEPTH(DEP)) dut (
        .PCLK_tx(clk), .PRESETn_tx(rst_n), .PADDR_tx_i(paddr), .PWDATA_tx_i(pwdata),
        .PWRITE_tx_i(pwrite), .PSELx_tx_i(psel), .PENABLE_tx_i(penable),
        .PRDATA_tx_o(prdata), .PREADY_tx_o(pready), .PSLVERR_tx_o(pslverr),
        .prescale_o(prescale_o), .command_o(command_o), .id_o(id_o),
        .datafield_o(datafield_o), .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o),
        .tx_ready_i(tx_ready), .busy_i(busy), .irq_o(irq)
    );

    int total = 0;
    int bad   = 0;

    // Reference model
    logic [11:0] fq [NCH][$];
    logic [15:0] m_pre [NCH];
    logic [15:0] m_df  [NCH];
    logic [7:0]  m_cmd [NCH];
    logic [7:0]  m_id  [NCH];
    logic [2:0]  m_flag[NCH];
    logic [2:0]  m_ien [NCH];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            fq[c].delete();
            m_pre[c] = '0; m_df[c] = '0; m_cmd[c] = '0; m_id[c] = '0;
            m_flag[c] = '0; m_ien[c] = '0;
        end
    endtask

    function automatic logic [15:0] m_val(input int ch, input int ofs);
        int lvl;
        lvl = fq[ch].size();
        case (ofs)
            'h00: return m_pre[ch];
            'h04: return {8'h0, m_cmd[ch]};
            'h0C: return {8'h0, m_id[ch]};
            'h10: return m_df[ch];
            'h14: return 16'(lvl * 64 + ((lvl == DEP) ? 4 : 0) + ((lvl == 0) ? 2 : 0) + (busy[ch] ? 1 : 0));
            'h18: return {13'h0, m_flag[ch]};
            'h1C: return {13'h0, m_ien[ch]};
            default: return 16'h0;
        endcase
    endfunction

    // Pops for every ready channel holding data; push_ch marks a same-cycle push.
    task automatic model_pop(input logic [NCH-1:0] rdy, input int push_ch);
        for (int c = 0; c < NCH; c++) begin
            if (rdy[c] && fq[c].size() > 0) begin
                if (fq[c].size() == 1 && push_ch != c) m_flag[c][1] = 1'b1;
                void'(fq[c].pop_front());
            end
        end
    endtask

    task automatic model_write(input logic [7:0] addr, input logic [15:0] d,
                               input logic [NCH-1:0] rdy, output logic e);
        int  ch, ofs;
        bit  full;
        ch   = int'(addr[7:5]);
        ofs  = int'(addr[4:0]);
        full = (ch < NCH) && (fq[ch].size() == DEP);
        e = (ch >= NCH) || (ofs % 4 != 0) || (ofs == 'h14) || (ofs == 'h08 && full);
        if (!e) begin
            case (ofs)
                'h00: m_pre[ch] = d;
                'h04: m_cmd[ch] = d[7:0];
                'h0C: m_id[ch]  = d[7:0];
                'h10: m_df[ch]  = d;
                'h18: m_flag[ch] = m_flag[ch] & ~d[2:0];
                'h1C: m_ien[ch] = d[2:0];
                default: ;
            endcase
        end
        if (ch < NCH && ofs == 'h08 && full) m_flag[ch][0] = 1'b1;
        model_pop(rdy, (!e && ofs == 'h08) ? ch : -1);
        if (!e && ofs == 'h08) fq[ch].push_back(d[11:0]);
    endtask

    task automatic wr(input logic [7:0] addr, input logic [15:0] d,
                      input logic [NCH-1:0] rdy, output logic obs_err);
        logic e;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = d;
        @(posedge clk); #1;
        penable = 1'b1; tx_ready = rdy;
        #1;
        obs_err = pslverr;
        model_write(addr, d, rdy, e);
        chk($sformatf("wr_err@%02h", addr), obs_err, e);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; tx_ready = '0;
    endtask

    task automatic rd(input logic [7:0] addr, output logic [15:0] obs);
        int ch, ofs;
        logic e;
        logic [15:0] ev;
        ch  = int'(addr[7:5]);
        ofs = int'(addr[4:0]);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = addr;
        e  = (ch >= NCH) || (ofs % 4 != 0);
        ev = e ? 16'h0 : m_val(ch, ofs);
        @(posedge clk); #1;
        penable = 1'b1;
        #1;
        obs = prdata;
        chk($sformatf("rd_data@%02h", addr), prdata, ev);
        chk($sformatf("rd_err@%02h", addr), pslverr, e);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic pop_pulse(input logic [NCH-1:0] rdy);
        @(posedge clk); #1;
        tx_ready = rdy;
        model_pop(rdy, -1);
        @(posedge clk); #1;
        tx_ready = '0;
    endtask

    task automatic chk_outs(input string tag);
        logic [NCH*16-1:0] ep, ed;
        logic [NCH*8-1:0]  ec, ei;
        logic [NCH-1:0]    ev;
        for (int c = 0; c < NCH; c++) begin
            ep[c*16 +: 16] = m_pre[c];
            ed[c*16 +: 16] = m_df[c];
            ec[c*8 +: 8]   = m_cmd[c];
            ei[c*8 +: 8]   = m_id[c];
            ev[c]          = (fq[c].size() != 0);
        end
        chk({tag, ".prescale"}, prescale_o, ep);
        chk({tag, ".datafield"}, datafield_o, ed);
        chk({tag, ".command"}, command_o, ec);
        chk({tag, ".id"}, id_o, ei);
        chk({tag, ".valid"}, tx_valid_o, ev);
        for (int c = 0; c < NCH; c++)
            if (ev[c]) chk($sformatf("%s.txdata%0d", tag, c), tx_data_o[c*12 +: 12], fq[c][0]);
    endtask

    task automatic chk_irq(input string tag);
        logic e;
        @(posedge clk); #1;
        e = 1'b0;
        for (int c = 0; c < NCH; c++) e = e | (|(m_flag[c] & m_ien[c]));
        chk(tag, irq, e);
    endtask

    initial begin
        logic        er;
        logic [15:0] d;
        int          ch, ofs, op;
        logic [NCH-1:0] rdy;

        model_reset();
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst.prdata", prdata, 0);
        chk("rst.irq", irq, 0);
        chk("rst.pslverr", pslverr, 0);
        chk("rst.pready", pready, 1);
        rst_n = 1'b1;
        chk_outs("rst");
        rd(8'h14, d);
        chk("rst.status0", d, 16'h0002);

        // Single push on ch1 then pop -> drained flag
        wr(8'h28, 16'h0ABC, '0, er);
        chk("push1.valid", tx_valid_o[1], 1);
        chk("push1.data", tx_data_o[23:12], 12'hABC);
        pop_pulse(2'b10);
        chk("pop1.valid", tx_valid_o[1], 0);
        rd(8'h38, d);
        chk("pop1.intflag", d, 16'h0002);

        // Overflow on ch0
        for (int i = 0; i <= DEP; i++) wr(8'h08, 16'($urandom), '0, er);
        chk("ovf.lastslverr", er, 1);
        rd(8'h14, d);
        chk("ovf.fullbit", d[2], 1);
        rd(8'h18, d);
        chk("ovf.flag", d[0], 1);
        wr(8'h1C, 16'h0001, '0, er);
        chk_irq("ovf.irq_on");
        chk("ovf.irq1", irq, 1);
        wr(8'h18, 16'h0001, '0, er);
        chk_irq("ovf.irq_off");
        chk("ovf.irq0", irq, 0);

        // Start bit self-clear and done flag
        wr(8'h04, 16'h0008, '0, er);
        busy = 2'b01;
        @(posedge clk); #1;
        m_cmd[0][3] = 1'b0;
        rd(8'h04, d);
        chk("start.cleared", d[3], 0);
        busy = 2'b00;
        @(posedge clk); #1;
        m_flag[0][2] = 1'b1;
        rd(8'h18, d);
        chk("done.flag", d[2], 1);

        // Error responses
        wr(8'h40, 16'h1234, '0, er);
        chk("err.badch_w", er, 1);
        rd(8'h40, d);
        wr(8'h02, 16'hBEEF, '0, er);
        chk("err.misal_w", er, 1);
        rd(8'h02, d);
        wr(8'h14, 16'hFFFF, '0, er);
        chk("err.status_w", er, 1);
        chk_outs("err");

        // Push into full FIFO with a simultaneous pop
        wr(8'h08, 16'h0555, 2'b01, er);
        chk("fullpp.err", er, 1);
        rd(8'h14, d);
        chk("fullpp.level", d[12:6], DEP - 1);
        wr(8'h08, 16'h0666, 2'b01, er);
        rd(8'h14, d);
        chk("pp.level", d[12:6], DEP - 1);
        chk_outs("pp");

        // Randomized traffic
        for (int it = 0; it < 300; it++) begin
            ch = ($urandom_range(0, 7) == 0) ? $urandom_range(NCH, 7) : $urandom_range(0, NCH - 1);
            ofs = ($urandom_range(0, 9) < 4) ? 'h08 : $urandom_range(0, 7) * 4;
            if ($urandom_range(0, 9) == 0) ofs = ofs | $urandom_range(1, 3);
            op = $urandom_range(0, 9);
            if (op <= 5) begin
                rdy = ($urandom_range(0, 3) == 0) ? NCH'($urandom) : '0;
                wr({ch[2:0], ofs[4:0]}, 16'($urandom), rdy, er);
            end else if (op <= 8) begin
                rd({ch[2:0], ofs[4:0]}, d);
            end else begin
                pop_pulse(NCH'($urandom_range(1, (1 << NCH) - 1)));
            end
            chk_outs($sformatf("rnd%0d", it));
            chk_irq($sformatf("rnd%0d.irq", it));
        end

        // Reset in the middle of an access
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h28; pwdata = 16'h0123;
        @(posedge clk); #1;
        penable = 1'b1;
        rst_n = 1'b0;
        #2;
        model_reset();
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        rst_n = 1'b1;
        chk("arst.irq", irq, 0);
        chk("arst.prdata", prdata, 0);
        chk_outs("arst");
        rd(8'h34, d);
        chk("arst.status1", d, 16'h0002);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
